yarp_execute_seq: RTL and testbench

Parametrised next-generation execute unit for the yarp core. It covers the full base ALU operation set at XLEN width, plus the RV32M multiply/divide operations, which run iteratively over multiple cycles. Sits between decode/operand fetch and writeback. Uses a valid/ready handshake on both input and output sides, and has a flush input for pipeline redirects.

---
 rtl/yarp_execute_seq.sv | 208 ++++++++++++++++++++
 tb/tb_yarp_execute_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/yarp_execute_seq.sv
// yarp_execute_seq: execute unit for the yarp core.
// Single-cycle base ALU ops plus iterative RV32M multiply (shift-add)
// and divide (restoring), one bit per cycle.
// Ports:
//   clk, reset_n            clock (rising edge), async active-low reset
//   valid_i / ready_o       request handshake; op_i, opr_a_i, opr_b_i captured on accept
//   flush_i                 abort anything in flight, block acceptance
//   valid_o / ready_i       result handshake; res_o held stable while valid_o
//   busy_o                  multi-cycle multiply/divide in progress
module yarp_execute_seq #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] opr_a_i,
  input  logic [XLEN-1:0] opr_b_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] res_o,
  output logic            busy_o
);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SRL    = 5'd3;
  localparam logic [4:0] OP_SRA    = 5'd4;
  localparam logic [4:0] OP_OR     = 5'd5;
  localparam logic [4:0] OP_AND    = 5'd6;
  localparam logic [4:0] OP_XOR    = 5'd7;
  localparam logic [4:0] OP_SLTU   = 5'd8;
  localparam logic [4:0] OP_SLT    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_REM    = 5'd22;
  localparam logic [4:0] OP_REMU   = 5'd23;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t              state_reg;
  logic [4:0]          op_reg;
  logic [XLEN-1:0]     opd_reg;   // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   acc_reg;   // {partial product | remainder, multiplier | quotient}
  logic [SHW:0]        cnt_reg;
  logic                qneg_reg;  // negate product / quotient at the end
  logic                rneg_reg;  // negate remainder at the end
  logic [XLEN-1:0]     res_reg;

  // ---------------- request decode ----------------
  logic            is_mul, is_div, is_rem_in;
  logic            a_signed, b_signed, a_sgn, b_sgn;
  logic [XLEN-1:0] a_mag, b_mag, special_res, alu_res;
  logic            div_special;
  logic [SHW-1:0]  shamt;

  always_comb begin
    is_mul    = (op_i[4:2] == 3'b100);
    is_div    = (op_i[4:2] == 3'b101);
    is_rem_in = (op_i == OP_REM) || (op_i == OP_REMU);
    a_signed  = 1'b0;
    b_signed  = 1'b0;
    if (is_mul) begin
      a_signed = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_MULHSU);
      b_signed = (op_i == OP_MUL) || (op_i == OP_MULH);
    end else if (is_div) begin
      a_signed = (op_i == OP_DIV) || (op_i == OP_REM);
      b_signed = a_signed;
    end
    a_sgn = a_signed & opr_a_i[XLEN-1];
    b_sgn = b_signed & opr_b_i[XLEN-1];
    a_mag = a_sgn ? (XLEN'(0) - opr_a_i) : opr_a_i;
    b_mag = b_sgn ? (XLEN'(0) - opr_b_i) : opr_b_i;

    // Zero divisor and MIN/-1 bypass the iteration entirely.
    div_special = (opr_b_i == '0) ||
                  (a_signed && (opr_a_i == MIN_NEG) && (opr_b_i == '1));
    if (opr_b_i == '0) special_res = is_rem_in ? opr_a_i : '1;
    else               special_res = is_rem_in ? '0 : MIN_NEG;

    shamt = opr_b_i[SHW-1:0];
    case (op_i)
      OP_ADD:  alu_res = opr_a_i + opr_b_i;
      OP_SUB:  alu_res = opr_a_i - opr_b_i;
      OP_SLL:  alu_res = opr_a_i << shamt;
      OP_SRL:  alu_res = opr_a_i >> shamt;
      OP_SRA:  alu_res = $signed(opr_a_i) >>> shamt;
      OP_OR:   alu_res = opr_a_i | opr_b_i;
      OP_AND:  alu_res = opr_a_i & opr_b_i;
      OP_XOR:  alu_res = opr_a_i ^ opr_b_i;
      OP_SLTU: alu_res = XLEN'(opr_a_i < opr_b_i);
      OP_SLT:  alu_res = XLEN'($signed(opr_a_i) < $signed(opr_b_i));
      default: alu_res = '0;
    endcase
  end

  // ---------------- iteration step ----------------
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fin;
  logic [XLEN-1:0]   mul_res, div_res, quot, rem;

  always_comb begin
    // Shift-add: add multiplicand to the upper half when the current
    // multiplier bit (acc LSB) is set, then shift the whole pair right.
    mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opd_reg} : '0);
    mul_next = {mul_sum, acc_reg[XLEN-1:1]};
    prod_fin = qneg_reg ? ((2*XLEN)'(0) - mul_next) : mul_next;
    mul_res  = (op_reg == OP_MUL) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];

    // Restoring division: bring in the next dividend bit, trial-subtract.
    div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    div_diff  = div_shift - {1'b0, opd_reg};
    div_ok    = ~div_diff[XLEN];
    div_next  = {(div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                 acc_reg[XLEN-2:0], div_ok};
    quot      = div_next[XLEN-1:0];
    rem       = div_next[2*XLEN-1:XLEN];
    if ((op_reg == OP_REM) || (op_reg == OP_REMU))
      div_res = rneg_reg ? (XLEN'(0) - rem) : rem;
    else
      div_res = qneg_reg ? (XLEN'(0) - quot) : quot;
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      op_reg    <= '0;
      opd_reg   <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      qneg_reg  <= 1'b0;
      rneg_reg  <= 1'b0;
      res_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (valid_i && !flush_i) begin
            op_reg <= op_i;
            if (is_mul) begin
              acc_reg   <= {{XLEN{1'b0}}, b_mag};
              opd_reg   <= a_mag;
              qneg_reg  <= a_sgn ^ b_sgn;
              rneg_reg  <= 1'b0;
              cnt_reg   <= (SHW+1)'(XLEN);
              state_reg <= S_MUL;
            end else if (is_div && div_special) begin
              res_reg   <= special_res;
              state_reg <= S_DONE;
            end else if (is_div) begin
              acc_reg   <= {{XLEN{1'b0}}, a_mag};
              opd_reg   <= b_mag;
              qneg_reg  <= a_sgn ^ b_sgn;
              rneg_reg  <= a_sgn;
              cnt_reg   <= (SHW+1)'(XLEN);
              state_reg <= S_DIV;
            end else begin
              res_reg   <= alu_res;
              state_reg <= S_DONE;
            end
          end
        end
        S_MUL: begin
          if (flush_i) begin
            state_reg <= S_IDLE;
          end else begin
            acc_reg <= mul_next;
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == (SHW+1)'(1)) begin
              res_reg   <= mul_res;
              state_reg <= S_DONE;
            end
          end
        end
        S_DIV: begin
          if (flush_i) begin
            state_reg <= S_IDLE;
          end else begin
            acc_reg <= div_next;
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == (SHW+1)'(1)) begin
              res_reg   <= div_res;
              state_reg <= S_DONE;
            end
          end
        end
        default: begin // S_DONE; flush wins over ready_i
          if (flush_i || ready_i) state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_o = reset_n && (state_reg == S_IDLE);
  assign valid_o = (state_reg == S_DONE);
  assign busy_o  = (state_reg == S_MUL) || (state_reg == S_DIV);
  assign res_o   = res_reg;

endmodule

// File: tb/tb_yarp_execute_seq.sv
module tb_yarp_execute_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [4:0]  op_i = '0;
  logic [31:0] opr_a_i = '0;
  logic [31:0] opr_b_i = '0;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] res_o;
  logic        busy_o;

  yarp_execute_seq #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .opr_a_i(opr_a_i), .opr_b_i(opr_b_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .res_o(res_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rise = 0;
  bit   prev_v = 1'b0;
  int   brun = 0;
  int   blast = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_v = 1'b0;
      brun   = 0;
    end else begin
      if (busy_o) brun = brun + 1;
      else if (brun != 0) begin
        blast = brun;
        brun  = 0;
      end
      if (valid_o && !prev_v) rise = cyc;
      prev_v = valid_o;
      if (valid_o && ready_i && !flush_i) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", res_o, 32'hxxxx_xxxx);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk({e.nm, "_res"}, res_o, e.res);
          chk({e.nm, "_lat"}, 32'(rise - e.acc), 32'(e.lat));
          $display("txn %s res=%h latency=%0d", e.nm, res_o, rise - e.acc);
        end
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string nm, input bit push);
    int t;
    t = 0;
    while (!ready_o && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!ready_o) chk({nm, "_issue_timeout"}, 32'(ready_o), 32'd1);
    op_i = op; opr_a_i = a; opr_b_i = b; valid_i = 1'b1;
    if (push) q.push_back('{res: exp, acc: cyc, lat: lat, nm: nm});
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while ((q.size() != 0 || !ready_o) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (q.size() != 0 || !ready_o) chk({nm, "_idle_timeout"}, 32'(q.size()), 32'd0);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_res", res_o, 32'd0);
    cycles(3);
    reset_n = 1'b1;
    cycles(1);
    chk("rst_ready", 32'(ready_o), 32'd1);

    // Single-cycle ALU ops
    issue(5'd0,  32'd5,          32'd7,          32'd12,         1, "add",  1);
    issue(5'd1,  32'd3,          32'd5,          32'hFFFF_FFFE,  1, "sub",  1);
    issue(5'd4,  32'h8000_0000,  32'd4,          32'hF800_0000,  1, "sra",  1);
    issue(5'd3,  32'h8000_0000,  32'd4,          32'h0800_0000,  1, "srl",  1);
    issue(5'd2,  32'd3,          32'h21,         32'd6,          1, "sll",  1);
    issue(5'd5,  32'hF0F0_0000,  32'h0000_0F0F,  32'hF0F0_0F0F,  1, "or",   1);
    issue(5'd6,  32'hFF00_FF00,  32'h0F0F_0F0F,  32'h0F00_0F00,  1, "and",  1);
    issue(5'd7,  32'hAAAA_5555,  32'hFFFF_0000,  32'h5555_5555,  1, "xor",  1);
    issue(5'd8,  32'hFFFF_FFFF,  32'd1,          32'd0,          1, "sltu", 1);
    issue(5'd9,  32'hFFFF_FFFF,  32'd1,          32'd1,          1, "slt",  1);
    issue(5'd10, 32'd9,          32'd9,          32'd0,          1, "undef", 1);
    wait_idle("alu");

    // Multiply
    issue(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu", 1);
    wait_idle("mulhu");
    chk("mul_busy_cycles", 32'(blast), 32'd32);
    issue(5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, "mul", 1);
    issue(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, "mulh_m1", 1);
    issue(5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu", 1);
    issue(5'd16, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_neg", 1);
    issue(5'd17, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh_min", 1);
    wait_idle("mul");

    // Divide and special cases
    issue(5'd20, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "div", 1);
    issue(5'd22, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "rem", 1);
    issue(5'd20, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_nb", 1);
    issue(5'd22, 32'd7,         32'hFFFF_FFFE, 32'd1,         33, "rem_nb", 1);
    issue(5'd21, 32'd100,       32'd7,         32'd14,        33, "divu", 1);
    issue(5'd23, 32'd100,       32'd7,         32'd2,         33, "remu", 1);
    issue(5'd21, 32'd7,         32'd0,         32'hFFFF_FFFF,  1, "divu_z", 1);
    issue(5'd23, 32'd7,         32'd0,         32'd7,          1, "remu_z", 1);
    issue(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,  1, "div_ovf", 1);
    issue(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          1, "rem_ovf", 1);
    wait_idle("div");

    // Backpressure in DONE
    ready_i = 1'b0;
    issue(5'd0, 32'd10, 32'd20, 32'd30, 1, "add_bp", 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(valid_o), 32'd1);
      chk("bp_res", res_o, 32'd30);
      chk("bp_ready", 32'(ready_o), 32'd0);
      cycles(1);
    end
    ready_i = 1'b1;
    cycles(1);
    chk("bp_release_ready", 32'(ready_o), 32'd1);
    issue(5'd7, 32'h1234_5678, 32'hFFFF_FFFF, 32'hEDCB_A987, 1, "xor_after_bp", 1);
    wait_idle("bp");

    // Flush in the middle of a multiply
    issue(5'd16, 32'd3, 32'd5, 32'd0, 33, "mul_flushed", 0);
    cycles(9);
    flush_i = 1'b1;
    cycles(1);
    flush_i = 1'b0;
    chk("flush_ready", 32'(ready_o), 32'd1);
    chk("flush_busy", 32'(busy_o), 32'd0);
    chk("flush_valid", 32'(valid_o), 32'd0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        if (valid_o) seen++;
        cycles(1);
      end
      chk("flush_no_valid", 32'(seen), 32'd0);
    end
    // flush together with a request in IDLE: nothing accepted
    valid_i = 1'b1; flush_i = 1'b1; op_i = 5'd0; opr_a_i = 32'd4; opr_b_i = 32'd4;
    cycles(1);
    valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_reject_valid", 32'(valid_o), 32'd0);
    issue(5'd0, 32'd1, 32'd1, 32'd2, 1, "add_after_flush", 1);
    wait_idle("flush");

    // Reset pulsed in the middle of a divide
    issue(5'd21, 32'd1000, 32'd3, 32'd0, 33, "div_reset", 0);
    cycles(10);
    reset_n = 1'b0;
    #1;
    chk("rstmid_valid", 32'(valid_o), 32'd0);
    chk("rstmid_busy", 32'(busy_o), 32'd0);
    chk("rstmid_res", res_o, 32'd0);
    chk("rstmid_ready", 32'(ready_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cycles(1);
    chk("rstmid_ready_after", 32'(ready_o), 32'd1);
    issue(5'd0, 32'd1, 32'd1, 32'd2, 1, "add_after_reset", 1);
    wait_idle("reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
